// File: rtl/pwm_dac.sv
// -----------------------------------------------------------------------------
// pwm_dac
//
// Audio output stage placed at the end of the effect chain. The block takes the
// final offset-binary sample stream (midscale = silence) and drives a 1-bit PWM
// pin. Incoming samples go into a small FIFO. One sample is released per PWM
// frame, so the bursty valid timing of the effect stages is decoupled from the
// fixed frame rate.
//
// Optional build feature (macro PWM_DAC_STAT_EN):
//   When the macro is defined, the block adds two saturating 16-bit event
//   counters, ovf_cnt_o and udr_cnt_o. They clear on reset and on IDLE entry.
//   When the macro is undefined, these ports and counters are absent.
//
// Parameters:
//   DATA_WIDTH - sample width and PWM counter width (frame = 2^DATA_WIDTH ticks)
//   FIFO_DEPTH - sample buffer entries (power of 2, >= 2)
//   PRESCALE   - clk cycles per PWM tick (>= 1)
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   en         - output enable; low idles the output at midscale
//   data_i     - sample from the effect chain
//   vld_i      - data_i valid (no backpressure)
//   pwm_o      - registered PWM output
//   ovf_o      - one-cycle pulse when a sample is dropped on a full FIFO
//   udr_o      - one-cycle pulse when a RUN frame boundary finds the FIFO empty
//   ovf_cnt_o  - saturating overflow event count (PWM_DAC_STAT_EN only)
//   udr_cnt_o  - saturating underrun event count (PWM_DAC_STAT_EN only)
// -----------------------------------------------------------------------------
module pwm_dac #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  vld_i,
  output logic                  pwm_o,
  output logic                  ovf_o,
  output logic                  udr_o
`ifdef PWM_DAC_STAT_EN
  ,
  output logic [15:0]           ovf_cnt_o,
  output logic [15:0]           udr_cnt_o
`endif
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int AW  = $clog2(FIFO_DEPTH);
  // The extra pointer MSB separates the full condition from the empty one.
  localparam int PW  = AW + 1;
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PSW-1:0]        PRE_LAST = PSW'(PRESCALE - 1);
  localparam logic [DATA_WIDTH-1:0] DUTY_MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] CNT_LAST = {DATA_WIDTH{1'b1}};
  localparam logic [PW-1:0]         OCC_FULL = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0]         OCC_HALF = PW'(FIFO_DEPTH / 2);

  // Playback state machine encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Saturating increment for the 16-bit event statistics.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [PSW-1:0]        pre_r;
  logic [DATA_WIDTH-1:0] cnt_r;
  logic [DATA_WIDTH-1:0] duty_r;
  logic [1:0]            state_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic                  tick_s;
  logic                  fb_s;
  logic [PW-1:0]         occ_s;
  logic                  empty_s;
  logic                  full_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic [1:0]            state_nxt_s;
  logic                  wr_en_s;
  logic                  pop_s;
  logic                  ovf_s;
  logic                  udr_s;
  logic                  flush_s;
  logic [DATA_WIDTH-1:0] duty_nxt_s;

  // PWM timebase decode: tick at the end of each prescale period, and the frame
  // boundary on the tick that wraps the PWM counter.
  always_comb begin
    tick_s = (pre_r == PRE_LAST);
    fb_s   = tick_s && (cnt_r == CNT_LAST);
  end

  // FIFO status decode. The occupancy comes straight from the pointer difference.
  always_comb begin
    occ_s   = wr_ptr_r - rd_ptr_r;
    empty_s = (occ_s == {PW{1'b0}});
    full_s  = (occ_s == OCC_FULL);
    head_s  = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Control decisions: next state, FIFO write/pop, event pulses, and flush.
  always_comb begin
    state_nxt_s = state_r;
    wr_en_s     = 1'b0;
    pop_s       = 1'b0;
    ovf_s       = 1'b0;
    udr_s       = 1'b0;
    flush_s     = 1'b0;
    if (!en) begin
      // Disabling from any state drops straight to IDLE. This can happen mid-frame.
      // An fb on this same edge is not reported as an underrun.
      state_nxt_s = ST_IDLE;
      flush_s     = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // The FIFO stays empty and vld_i is ignored while leaving IDLE.
          state_nxt_s = ST_PRIME;
          flush_s     = 1'b1;
        end
        ST_PRIME: begin
          wr_en_s = vld_i && !full_s;
          ovf_s   = vld_i && full_s;
          // Use the occupancy after this edge's write. RUN then starts on the
          // write that reaches half depth.
          if ((occ_s + PW'(wr_en_s)) >= OCC_HALF) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PRIME;
          end
        end
        ST_RUN: begin
          pop_s   = fb_s && !empty_s;
          udr_s   = fb_s && empty_s;
          // A pop on a full FIFO frees the slot the write needs in the same edge.
          wr_en_s = vld_i && (!full_s || pop_s);
          ovf_s   = vld_i && full_s && !pop_s;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          flush_s     = 1'b1;
        end
      endcase
    end
  end

  // Duty selection: midscale whenever the FIFO is flushed, else the popped head.
  always_comb begin
    duty_nxt_s = duty_r;
    if (flush_s) begin
      duty_nxt_s = DUTY_MID;
    end else if (pop_s) begin
      duty_nxt_s = head_s;
    end else begin
      duty_nxt_s = duty_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  // Free-running prescaler and PWM counter. These run in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_r <= {PSW{1'b0}};
      cnt_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (tick_s) begin
        pre_r <= {PSW{1'b0}};
        cnt_r <= cnt_r + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        pre_r <= pre_r + {{(PSW-1){1'b0}}, 1'b1};
        cnt_r <= cnt_r;
      end
    end
  end

  // Playback state and current duty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      duty_r  <= DUTY_MID;
    end else begin
      state_r <= state_nxt_s;
      duty_r  <= duty_nxt_s;
    end
  end

  // FIFO pointers. A flush clears both pointers, which empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else if (flush_s) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // FIFO storage. On a full FIFO, a write that shares an edge with a pop lands
  // in the slot being popped. The pop reads the old head before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= data_i;
      end else begin
        mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
      end
    end
  end

  // Registered outputs: PWM compare against the current duty, plus event pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_o <= 1'b0;
      ovf_o <= 1'b0;
      udr_o <= 1'b0;
    end else begin
      pwm_o <= (cnt_r < duty_r);
      ovf_o <= ovf_s;
      udr_o <= udr_s;
    end
  end

`ifdef PWM_DAC_STAT_EN
  // Event statistics. They saturate at all-ones and clear whenever the FIFO is flushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt_o <= 16'd0;
      udr_cnt_o <= 16'd0;
    end else if (flush_s) begin
      ovf_cnt_o <= 16'd0;
      udr_cnt_o <= 16'd0;
    end else begin
      if (ovf_s) begin
        ovf_cnt_o <= sat_inc16(ovf_cnt_o);
      end else begin
        ovf_cnt_o <= ovf_cnt_o;
      end
      if (udr_s) begin
        udr_cnt_o <= sat_inc16(udr_cnt_o);
      end else begin
        udr_cnt_o <= udr_cnt_o;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pwm_dac.sv
// -----------------------------------------------------------------------------
// tb_pwm_dac
//
// Directed self-checking bench for pwm_dac with DATA_WIDTH=8, FIFO_DEPTH=4 and
// PRESCALE=1, so one frame is 256 cycles. Edge k is the k-th rising clk edge
// after reset release, and outputs are sampled 1 time unit after each edge. The
// sample taken after edge k shows the compare of cnt=(k-1)%256 against the duty
// held before edge k. Window W_n therefore covers samples 256n+1..256n+256 and
// plays the duty loaded at frame-boundary edge 256n.
// -----------------------------------------------------------------------------
module tb_pwm_dac;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] data_i;
  logic       vld_i;
  logic       pwm_o;
  logic       ovf_o;
  logic       udr_o;
`ifdef PWM_DAC_STAT_EN
  logic [15:0] ovf_cnt;
  logic [15:0] udr_cnt;
`endif

  int cyc;
  int hi_acc;
  int ovf_acc;
  int udr_acc;
  int passes;
  int checks;

  // Scheduled input event: a write (data v) or an en change (v[0]) at edge 'at'.
  typedef struct {
    int       at;
    bit       is_en;
    logic [7:0] v;
  } ev_t;
  ev_t ev_q[$];

  pwm_dac #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4),
    .PRESCALE  (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .data_i(data_i),
    .vld_i (vld_i),
    .pwm_o (pwm_o),
    .ovf_o (ovf_o),
    .udr_o (udr_o)
`ifdef PWM_DAC_STAT_EN
    ,
    .ovf_cnt_o(ovf_cnt),
    .udr_cnt_o(udr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic add_wr(input int at, input logic [7:0] v);
    ev_q.push_back('{at: at, is_en: 1'b0, v: v});
  endtask

  task automatic add_en(input int at, input logic v);
    ev_q.push_back('{at: at, is_en: 1'b1, v: {7'd0, v}});
  endtask

  // One clock: sample outputs after the edge, accumulate, then drive next inputs.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (pwm_o === 1'b1) hi_acc++;
    if (ovf_o === 1'b1) ovf_acc++;
    if (udr_o === 1'b1) udr_acc++;
    vld_i = 1'b0;
    foreach (ev_q[i]) begin
      if (ev_q[i].at == cyc + 1) begin
        if (ev_q[i].is_en) begin
          en = ev_q[i].v[0];
        end else begin
          vld_i  = 1'b1;
          data_i = ev_q[i].v;
        end
      end
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) cycle();
  endtask

  // Finish a 256-cycle window at sample 'wend' and check its pwm high count.
  task automatic win(input int wend, input int exp, input string tag);
    run_to(wend);
    chk(tag, hi_acc, exp);
    hi_acc = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    passes = 0; checks = 0;
    cyc = 0; hi_acc = 0; ovf_acc = 0; udr_acc = 0;
    rst = 1'b0; en = 1'b0; vld_i = 1'b0; data_i = 8'h00;

    // ---- Reset state, then idle playback at midscale ----
    repeat (3) cycle();
    chk("reset_pwm", pwm_o, 32'd0);
    chk("reset_ovf", ovf_o, 32'd0);
    chk("reset_udr", udr_o, 32'd0);
    rst = 1'b1; cyc = 0; hi_acc = 0;
    win(256, 128, "idle_w0");
    win(512, 128, "idle_w1");

    // ---- Asynchronous reset mid-frame while pwm_o is high ----
    run_to(522);
    chk("pre_rst_pwm_high", pwm_o, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_pwm", pwm_o, 32'd0);
    chk("async_rst_ovf", ovf_o, 32'd0);
    chk("async_rst_udr", udr_o, 32'd0);
    repeat (3) cycle();
    chk("rst_hold_pwm", pwm_o, 32'd0);

    // ---- Schedule the rest of the run, then release with en=1 ----
    add_wr(11, 8'h40); add_wr(21, 8'hC0); add_wr(31, 8'h00);
    add_en(1281, 1'b0); add_en(1282, 1'b1);
    add_wr(1283, 8'h10); add_wr(1284, 8'h11); add_wr(1285, 8'h12);
    add_wr(1286, 8'h13); add_wr(1287, 8'h14);
    add_wr(1536, 8'h55);
    add_wr(1540, 8'h66);
    add_wr(2570, 8'hFF);
    add_wr(2830, 8'h00);
    add_wr(3082, 8'h20); add_wr(3084, 8'h30); add_wr(3086, 8'h40);
    add_en(3101, 1'b0); add_en(3111, 1'b1);
    add_wr(3120, 8'h60); add_wr(3340, 8'h70);
    rst = 1'b1; en = 1'b1; cyc = 0; hi_acc = 0; ovf_acc = 0; udr_acc = 0;

    // ---- Priming and playback ----
    win(256, 128, "prime_frame_mid");
    win(512, 64, "play_40");
    win(768, 192, "play_c0");
    win(1024, 0, "play_00");
    chk("udr_pulse_fb4", udr_o, 32'd1);
    chk("udr_count_fb4", udr_acc, 32'd1);
    run_to(1025);
    chk("udr_one_cycle", udr_o, 32'd0);
    win(1280, 0, "udr_duty_hold");
    chk("playback_no_ovf", ovf_acc, 32'd0);
    chk("udr_count_fb5", udr_acc, 32'd2);
`ifdef PWM_DAC_STAT_EN
    chk("stat_udr_cnt", udr_cnt, 32'd2);
    chk("stat_ovf_cnt_zero", ovf_cnt, 32'd0);
`endif
    ovf_acc = 0; udr_acc = 0;

    // ---- Overflow on the fifth back-to-back write after re-prime ----
    run_to(1286);
    chk("ovf_before_5th", ovf_o, 32'd0);
    run_to(1287);
    chk("ovf_on_5th", ovf_o, 32'd1);
    run_to(1288);
    chk("ovf_one_cycle", ovf_o, 32'd0);
    // The IDLE-entry edge takes midscale mid-frame. The first sample keeps duty 0.
    win(1536, 127, "idle_entry_frame");

    // ---- Pop and write in the same fb edge on a full FIFO ----
    chk("pop_write_no_ovf", ovf_o, 32'd0);
    run_to(1540);
    chk("still_full_ovf", ovf_o, 32'd1);
    chk("ovf_count", ovf_acc, 32'd2);
    win(1792, 16, "play_10");
    win(2048, 17, "play_11");
    win(2304, 18, "play_12");
    win(2560, 19, "play_13");
    win(2816, 85, "play_55");

    // ---- Extremes ----
    win(3072, 255, "play_ff");

    // ---- en drop mid-frame with three entries queued ----
    run_to(3100);
`ifdef PWM_DAC_STAT_EN
    chk("stat_ovf_before_idle", ovf_cnt, 32'd2);
`endif
    run_to(3101);
    chk("en_drop_no_udr", udr_o, 32'd0);
    run_to(3112);
`ifdef PWM_DAC_STAT_EN
    chk("stat_ovf_cleared", ovf_cnt, 32'd0);
    chk("stat_udr_cleared", udr_cnt, 32'd0);
`endif
    // duty 0x00 until the drop, then midscale for cnt 29..127.
    win(3328, 99, "en_drop_frame");
    chk("prime_fb_no_udr", udr_o, 32'd0);
    chk("no_udr_since_reprime", udr_acc, 32'd0);
    win(3584, 128, "reprime_no_pop");
    win(3840, 96, "replay_60");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pwm_dac.md
Name: pwm_dac

Overview:
- Output stage directly downstream of the effect chain (eff_* blocks). It consumes the final `data_o`/`vld_o` sample stream and drives a 1-bit PWM audio output pin.
- Samples enter a small FIFO and are released one per PWM frame, decoupling bursty effect-stage valid timing from the fixed PWM frame rate.
- Samples are unsigned offset-binary; midscale means silence.

Parameters:
- DATA_WIDTH, 8: sample width; also the PWM counter width, so one frame = 2^DATA_WIDTH ticks.
- FIFO_DEPTH, 4: sample buffer entries; must be a power of 2 and at least 2.
- PRESCALE, 1: clk cycles per PWM tick; must be at least 1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset. Assertion clears all state immediately, independent of clk.
- en, input, 1: output enable. When low the block idles at midscale.
- data_i, input, DATA_WIDTH: sample from the effect chain.
- vld_i, input, 1: data_i valid. There is no backpressure.
- pwm_o, output, 1: PWM output, registered.
- ovf_o, output, 1: one-cycle pulse when a sample is dropped because the FIFO is full.
- udr_o, output, 1: one-cycle pulse when a RUN-state frame boundary finds the FIFO empty.

Behaviour:
- Reset values:
  - pwm_o=0, ovf_o=0, udr_o=0.
  - PWM counter cnt=0, prescaler=0.
  - duty=2^(DATA_WIDTH-1).
  - FIFO empty; state=IDLE.
- Prescaler:
  - Counts 0..PRESCALE-1; tick is asserted when it equals PRESCALE-1.
  - cnt increments on tick and wraps from 2^DATA_WIDTH-1 to 0.
  - Frame boundary (fb) = tick while cnt = 2^DATA_WIDTH-1.
- PWM output:
  - pwm_o(t+1) = (cnt(t) < duty(t)), unsigned compare; one-cycle latency.
  - duty=0 gives a constant low.
  - duty=2^DATA_WIDTH-1 gives high for all but one tick per frame.
- cnt and the prescaler run freely in every state.
- State machine:
  - IDLE:
    - FIFO held empty; vld_i ignored, so no ovf_o.
    - duty forced to midscale.
    - en=1 -> PRIME on the next cycle.
  - PRIME:
    - Writes accepted.
    - No pops; duty unchanged; fb does not raise udr_o.
    - Occupancy >= FIFO_DEPTH/2 -> RUN.
    - en=0 -> IDLE.
  - RUN:
    - On fb, if the FIFO is non-empty: pop, and duty <= head in the same edge that cnt wraps to 0.
    - On fb, if the FIFO is empty: duty holds its last value and udr_o pulses for one cycle. State stays RUN (no re-prime).
    - en=0 -> IDLE.
- IDLE entry, from any state (on the edge where en is sampled low):
  - FIFO flushed (pointers cleared).
  - duty <= midscale.
  - The mid-frame duty change is accepted.
- FIFO write rules:
  - Write on vld_i when state is not IDLE and the FIFO is not full.
  - Full and vld_i with no pop in the same cycle: sample dropped, ovf_o pulses for one cycle, contents untouched.
  - Full and vld_i with a pop in the same cycle: the pop frees the slot, the write is accepted, no ovf_o.
  - Empty with vld_i in the same cycle as an fb pop attempt: no bypass. udr_o pulses and the sample is stored.
- FIFO structure:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
  - Occupancy = wr_ptr - rd_ptr.
- Reset mid-frame: all outputs return to reset values immediately. After release, operation restarts from cnt=0 and state IDLE.

Optional Feature:
- Macro: PWM_DAC_STAT_EN.
- Defined:
  - Adds outputs ovf_cnt_o[15:0] and udr_cnt_o[15:0].
  - Each increments on its event pulse and saturates at 16'hFFFF.
  - Both clear on reset and on IDLE entry.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
All scenarios use DATA_WIDTH=8, FIFO_DEPTH=4, PRESCALE=1, so one frame = 256 cycles.
- Reset: assert rst low mid-frame with no clock edge -> pwm_o=0, ovf_o=0, udr_o=0 immediately. Release with en=0 -> pwm_o high for exactly 128 of every 256 cycles.
- Priming and playback:
  - Stimulus: en=1, then write 0x40, 0xC0, 0x00 on non-consecutive cycles within one frame.
  - RUN entered on the 2nd write; the next fb loads 0x40.
  - Required pwm_o high counts in successive frames: 64, then 192, then 0.
  - At the 4th fb: udr_o pulses once and duty stays 0.
- Overflow: in PRIME, 5 consecutive vld_i writes 0x10..0x14 before any fb -> ovf_o pulses once, on the 5th write. Frames then play duties 0x10, 0x11, 0x12, 0x13.
- Simultaneous pop and write on a full FIFO: hold the FIFO full, assert vld_i with 0x55 on the fb cycle -> no ovf_o, occupancy stays 4, and 0x55 plays four frames later.
- Extremes: duty 0xFF -> pwm_o high 255 of 256 cycles. Duty 0x00 -> pwm_o constantly low.
- en deassert mid-frame in RUN with 3 entries queued:
  - Next cycle: state IDLE, FIFO empty, duty=0x80, no udr_o.
  - Re-enable: PRIME is required again before any pop.
  - With PWM_DAC_STAT_EN defined: both counters read 0 after re-enable.
